// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Hazard-controller port bundle: pipeline status in, sequencing out.
// Revision    : 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_jump;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_rd;
    logic             ex_regwrite;
    logic [1:0]       ex_memtoreg;
    logic             ex_branch_taken;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic [1:0]       mem_memtoreg;
    logic             mem_dmem_req;
    logic             dmem_ready;
    logic [4:0]       wb_rd;
    logic             wb_regwrite;
    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
        output ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memtoreg, ex_branch_taken,
        output mem_rd, mem_regwrite, mem_memtoreg, mem_dmem_req, dmem_ready,
        output wb_rd, wb_regwrite,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush,
        input  mem_wb_bubble, fwd_a, fwd_b, mem_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
        input  ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memtoreg, ex_branch_taken,
        input  mem_rd, mem_regwrite, mem_memtoreg, mem_dmem_req, dmem_ready,
        input  wb_rd, wb_regwrite,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush,
        output mem_wb_bubble, fwd_a, fwd_b, mem_timeout, stall_cycles, flush_events
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : 5-stage pipeline sequencing: load-use stall, flushes, dmem freeze, forwarding.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int c_WAIT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_timeout;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    r_flush_events;

    logic w_freeze, w_load_use, w_stall;
    logic w_pc_we, w_if_id_we, w_id_ex_we, w_ex_mem_we;
    logic w_if_id_flush, w_id_ex_flush, w_mem_wb_bubble;
    logic [1:0] w_fwd_a, w_fwd_b;

    assign w_freeze = ((r_state == ST_RUN) && bus.mem_dmem_req && !bus.dmem_ready) ||
                      ((r_state == ST_MEM_WAIT) && !bus.dmem_ready) ||
                      (r_state == ST_HALT);

    assign w_load_use = (bus.ex_memtoreg == 2'b01) && bus.ex_regwrite && (bus.ex_rd != 5'd0) &&
                        ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                         (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

    // A taken branch squashes the dependent instruction, so it cannot stall.
    assign w_stall = w_freeze || (!bus.ex_branch_taken && w_load_use);

    always_comb begin
        w_pc_we         = 1'b1;
        w_if_id_we      = 1'b1;
        w_id_ex_we      = 1'b1;
        w_ex_mem_we     = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_mem_wb_bubble = 1'b0;
        if (!rst_n || w_freeze) begin
            w_pc_we         = 1'b0;
            w_if_id_we      = 1'b0;
            w_id_ex_we      = 1'b0;
            w_ex_mem_we     = 1'b0;
            w_mem_wb_bubble = 1'b1;
        end else if (bus.ex_branch_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_we       = 1'b0;
            w_if_id_we    = 1'b0;
            w_id_ex_flush = 1'b1;
        end else if (bus.id_jump) begin
            w_if_id_flush = 1'b1;
        end
    end

    // A MEM-stage load match is impossible after the load-use stall, so memtoreg=01 falls through.
    function automatic logic [1:0] f_fwd(input logic [4:0] src,
                                         input logic [4:0] mem_rd, input logic mem_rw,
                                         input logic [1:0] mem_m2r,
                                         input logic [4:0] wb_rd, input logic wb_rw);
        logic w_mem_hit;
        w_mem_hit = mem_rw && (mem_rd != 5'd0) && (mem_rd == src);
        if (w_mem_hit && (mem_m2r == 2'b10))
            return 2'b11;
        else if (w_mem_hit && (mem_m2r == 2'b00))
            return 2'b10;
        else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_fwd_a = f_fwd(bus.ex_rs, bus.mem_rd, bus.mem_regwrite, bus.mem_memtoreg,
                        bus.wb_rd, bus.wb_regwrite);
        w_fwd_b = f_fwd(bus.ex_rt, bus.mem_rd, bus.mem_regwrite, bus.mem_memtoreg,
                        bus.wb_rd, bus.wb_regwrite);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.mem_dmem_req && !bus.dmem_ready) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                        if (r_wait_cnt == c_WAIT_LAST) begin
                            r_state       <= ST_HALT;
                            r_mem_timeout <= 1'b1;
                        end
                    end
                end
                ST_HALT: r_mem_timeout <= 1'b1;
                default: r_state <= ST_RUN;
            endcase
            if (w_stall)
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_if_id_flush || w_id_ex_flush)
                r_flush_events <= r_flush_events + CNT_W'(1);
        end
    end

    assign bus.pc_we         = w_pc_we;
    assign bus.if_id_we      = w_if_id_we;
    assign bus.id_ex_we      = w_id_ex_we;
    assign bus.ex_mem_we     = w_ex_mem_we;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_ex_flush   = w_id_ex_flush;
    assign bus.mem_wb_bubble = w_mem_wb_bubble;
    assign bus.fwd_a         = w_fwd_a;
    assign bus.fwd_b         = w_fwd_b;
    assign bus.mem_timeout   = r_mem_timeout;
    assign bus.stall_cycles  = r_stall_cycles;
    assign bus.flush_events  = r_flush_events;
endmodule
`default_nettype wire
